cpu_int_sequencer: RTL and testbench
====================================

// Module: cpu_int_sequencer
// PURPOSE
//  Interrupt/BRK entry sequencer; drives the CPU register file's write side
//  (we_sp/we_ps/we_pc, shared 8-bit data, 16-bit PC) from register snapshots.
//  Pushes PCH, PCL and PS to the stack page, fetches the 16-bit vector,
//  then writes SP, PS (I set) and PC back. Sits beside the control FSM.
// PARAMETERS
//  STACK_PAGE  8'h01     high byte of every stack address
//  NMI_VECTOR  16'hFFFA  low-byte address of the NMI vector
//  IRQ_VECTOR  16'hFFFE  low-byte address of the IRQ/BRK vector
// PORTS
//  clk        in   1   clock
//  reset      in   1   reset, asynchronous, active-high
//  irq        in   1   level IRQ request, masked while ps[2]=1
//  nmi        in   1   NMI request, rising-edge sensitive (CPU_NMI_EN only)
//  brk_req    in   1   software BRK request, level, sampled at accept
//  can_take   in   1   controller at instruction boundary; accept allowed
//  pc         in   16  current PC (already advanced for BRK)
//  ps         in   8   current status
//  sp         in   8   current stack pointer
//  busy       out  1   sequence in progress
//  done       out  1   one-cycle pulse in final write cycle
//  reg_data   out  8   data for SP/PS writes
//  pc_out     out  16  data for PC write
//  we_sp/we_ps/we_pc  out 1 each  register write strobes, 1 cycle each
//  mem_req    out  1   bus request
//  mem_we     out  1   1=write, 0=read
//  mem_addr   out  16  bus address
//  mem_wdata  out  8   write data
//  mem_rdata  in   8   read data, valid with mem_ack
//  mem_ack    in   1   1-cycle completion; may arrive in first req cycle
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, nmi_pend=0, edge history=0.
//  Also aborts any sequence; no further pushes/writes.
//  Accept: IDLE & can_take & (nmi_pend | brk_req | (irq & ~ps[2])).
//  Priority NMI > BRK > IRQ. Latch pc/ps/sp into snapshots, sp_w=sp.
//  Inputs ignored while busy.
//  Source kinds: NMI->NMI_VECTOR, B=0; BRK->IRQ_VECTOR, B=1;
//  IRQ->IRQ_VECTOR, B=0.
//  States: IDLE->PUSH_PCH->PUSH_PCL->PUSH_PS->VEC_LO->VEC_HI->WR_SP->WR_PC_PS->IDLE.
//  busy=1 from cycle after accept through WR_PC_PS.
//  Push states: mem_req=1, mem_we=1, mem_addr={STACK_PAGE,sp_w},
//  mem_wdata = PCH / PCL / (ps|8'h20 with bit4=B).
//  On ack: sp_w=sp_w-1 mod 256 (00->FF wraps); advance state.
//  VEC_LO/HI: read vec, vec+1; latch mem_rdata on ack.
//  req/addr/we/wdata stable until ack; req drops the cycle after ack.
//  WR_SP: reg_data=sp_w, we_sp=1.
//  WR_PC_PS: pc_out={hi,lo}, we_pc=1, reg_data=ps_snap|8'h04, we_ps=1, done=1.
//  we_sp and we_ps never share a cycle (shared reg_data bus).
//  Latency: zero-wait memory -> busy exactly 7 cycles, accept to done.
//  Each wait cycle extends it by one.
//  Simultaneous requests: highest priority taken; lower ones stay pending
//  (IRQ level, BRK level) and are re-evaluated in IDLE after done.
// CONFIGURATION
//  CPU_NMI_EN defined: nmi rising-edge detector sets nmi_pend.
//  nmi_pend is cleared on accepting an NMI sequence.
//  An edge during busy stays pending and is taken next.
//  CPU_NMI_EN undefined: nmi ignored, nmi_pend held 0, NMI_VECTOR unused.
// TESTING
//  IRQ: pc=1234, ps=20, sp=FD, FFFE=00, FFFF=80, zero-wait ->
//    writes 01FD=12, 01FC=34, 01FB=20; SP=FA, PS=24, PC=8000; 7 busy cycles.
//  BRK: pc=0302, ps=00, sp=FD -> pushed PS=30, then PS=04, PC from FFFE/F.
//  Masked IRQ: ps=24, irq=1, can_take=1 for 20 cycles -> busy stays 0.
//  Wrap: sp=01 -> pushes at 0101, 0100, 01FF; final SP=FE.
//  Wait states: ack after 3 cycles per access -> req/addr stable, busy=17.
//  Reset mid-PUSH_PCL: all outputs 0, IDLE; no we_* pulse follows.
//  CPU_NMI_EN: nmi edge + irq in same cycle -> vector FFFA first;
//    IRQ taken right after done; NMI edge while busy -> taken after done.

Source files
------------

// File: rtl/cpu_int_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_int_sequencer
//   Interrupt / BRK entry sequencer. Sits beside the CPU control FSM. When the
//   controller reports an instruction boundary (can_take), an interrupt source
//   is accepted. The sequencer then pushes PCH, PCL and PS to the stack page,
//   fetches the 16-bit vector, and finally writes SP, then PS (I set) and PC
//   into the CPU register file.
//
//   Optional feature: define CPU_NMI_EN to enable the NMI rising-edge detector.
//   Without it, nmi is ignored and no NMI sequence is ever started.
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   irq                   level IRQ request, masked while ps[2]=1
//   nmi                   NMI request, rising-edge sensitive (CPU_NMI_EN only)
//   brk_req               software BRK request, level
//   can_take              controller at instruction boundary
//   pc, ps, sp            live CPU registers, snapshotted at accept
//   busy                  sequence in progress
//   done                  one-cycle pulse in the final write cycle
//   reg_data              shared data bus for SP / PS writes
//   pc_out                data for PC write
//   we_sp, we_ps, we_pc   register write strobes
//   mem_req, mem_we       bus request, 1=write
//   mem_addr, mem_wdata   bus address / write data
//   mem_rdata, mem_ack    read data, 1-cycle completion
// -----------------------------------------------------------------------------
module cpu_int_sequencer #(
  parameter logic [7:0]  STACK_PAGE = 8'h01,
  parameter logic [15:0] NMI_VECTOR = 16'hFFFA,
  parameter logic [15:0] IRQ_VECTOR = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irq,
  input  logic        nmi,
  input  logic        brk_req,
  input  logic        can_take,
  input  logic [15:0] pc,
  input  logic [7:0]  ps,
  input  logic [7:0]  sp,
  output logic        busy,
  output logic        done,
  output logic [7:0]  reg_data,
  output logic [15:0] pc_out,
  output logic        we_sp,
  output logic        we_ps,
  output logic        we_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  // state    | meaning
  // IDLE     | waiting for an accepted interrupt source
  // PUSH_PCH | writing PC high byte to stack
  // PUSH_PCL | writing PC low byte to stack
  // PUSH_PS  | writing status (bit5=1, bit4=B) to stack
  // VEC_LO   | reading vector low byte
  // VEC_HI   | reading vector high byte
  // WR_SP    | writing decremented SP
  // WR_PC_PS | writing PC from vector and PS with I set; done pulse
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PUSH_PCH = 3'd1,
    S_PUSH_PCL = 3'd2,
    S_PUSH_PS  = 3'd3,
    S_VEC_LO   = 3'd4,
    S_VEC_HI   = 3'd5,
    S_WR_SP    = 3'd6,
    S_WR_PC_PS = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_snap;
  logic [7:0]  ps_snap;
  logic [7:0]  sp_w;
  logic        src_nmi;
  logic        b_flag;
  logic [7:0]  vec_lo, vec_hi;

  logic        nmi_req;
  logic        accept;
  logic        take_nmi;
  logic        take_brk;
  logic        push_state;
  logic [15:0] vec_base;

  assign accept   = (state == S_IDLE) & can_take & (nmi_req | brk_req | (irq & ~ps[2]));
  assign take_nmi = accept & nmi_req;
  assign take_brk = accept & ~nmi_req & brk_req;

  assign push_state = (state == S_PUSH_PCH) | (state == S_PUSH_PCL) | (state == S_PUSH_PS);
  assign vec_base   = src_nmi ? NMI_VECTOR : IRQ_VECTOR;

`ifdef CPU_NMI_EN
  logic nmi_q;
  logic nmi_pend;

  // A fresh edge counts in the same cycle so that it wins over a coincident IRQ;
  // an edge that arrives while busy stays pending until the next accept.
  assign nmi_req = nmi_pend | (nmi & ~nmi_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nmi_q    <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      nmi_q    <= nmi;
      nmi_pend <= nmi_req & ~take_nmi;
    end
  end
`else
  logic unused_nmi;
  assign unused_nmi = nmi;
  assign nmi_req    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Snapshot, stack pointer and vector datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_snap <= '0;
      ps_snap <= '0;
      sp_w    <= '0;
      src_nmi <= 1'b0;
      b_flag  <= 1'b0;
      vec_lo  <= '0;
      vec_hi  <= '0;
    end else begin
      if (accept) begin
        pc_snap <= pc;
        ps_snap <= ps;
        sp_w    <= sp;
        src_nmi <= take_nmi;
        b_flag  <= take_brk;
      end
      if (push_state && mem_ack) sp_w <= sp_w - 8'd1;
      if (state == S_VEC_LO && mem_ack) vec_lo <= mem_rdata;
      if (state == S_VEC_HI && mem_ack) vec_hi <= mem_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept)  state_nxt = S_PUSH_PCH;
      S_PUSH_PCH: if (mem_ack) state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: if (mem_ack) state_nxt = S_PUSH_PS;
      S_PUSH_PS:  if (mem_ack) state_nxt = S_VEC_LO;
      S_VEC_LO:   if (mem_ack) state_nxt = S_VEC_HI;
      S_VEC_HI:   if (mem_ack) state_nxt = S_WR_SP;
      S_WR_SP:    state_nxt = S_WR_PC_PS;
      S_WR_PC_PS: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; IDLE (and therefore reset) drives all zeros.
  always_comb begin
    busy      = (state != S_IDLE);
    done      = 1'b0;
    reg_data  = '0;
    pc_out    = '0;
    we_sp     = 1'b0;
    we_ps     = 1'b0;
    we_pc     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_PUSH_PCH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp_w};
        mem_wdata = pc_snap[15:8];
      end
      S_PUSH_PCL: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp_w};
        mem_wdata = pc_snap[7:0];
      end
      S_PUSH_PS: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {STACK_PAGE, sp_w};
        mem_wdata = {ps_snap[7:6], 1'b1, b_flag, ps_snap[3:0]};
      end
      S_VEC_LO: begin
        mem_req  = 1'b1;
        mem_addr = vec_base;
      end
      S_VEC_HI: begin
        mem_req  = 1'b1;
        mem_addr = vec_base + 16'd1;
      end
      S_WR_SP: begin
        reg_data = sp_w;
        we_sp    = 1'b1;
      end
      S_WR_PC_PS: begin
        pc_out   = {vec_hi, vec_lo};
        we_pc    = 1'b1;
        reg_data = ps_snap | 8'h04;
        we_ps    = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_int_sequencer.sv
module tb_cpu_int_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq, nmi, brk_req, can_take;
  logic [15:0] pc;
  logic [7:0]  ps, sp;
  logic        busy, done;
  logic [7:0]  reg_data;
  logic [15:0] pc_out;
  logic        we_sp, we_ps, we_pc;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  cpu_int_sequencer dut (
    .clk(clk), .reset(reset), .irq(irq), .nmi(nmi), .brk_req(brk_req),
    .can_take(can_take), .pc(pc), .ps(ps), .sp(sp), .busy(busy), .done(done),
    .reg_data(reg_data), .pc_out(pc_out), .we_sp(we_sp), .we_ps(we_ps),
    .we_pc(we_pc), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit   [7:0]  mem [0:65535];
  logic [23:0] wlog [$];
  int          cur_waits;
  int          req_cnt;
  logic [24:0] req_snap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus slave model, evaluated at each negedge: acks after cur_waits extra cycles,
  // and checks that an outstanding request holds its address/direction/data.
  task automatic mem_step();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    if (mem_req) begin
      if (req_cnt == 0) req_snap = {mem_addr, mem_we, mem_wdata};
      else chk("req_stable", {7'd0, mem_addr, mem_we, mem_wdata}, {7'd0, req_snap});
      req_cnt++;
      if (req_cnt > cur_waits) begin
        mem_ack = 1'b1;
        req_cnt = 0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wlog.push_back({mem_addr, mem_wdata});
        end else begin
          mem_rdata = mem[mem_addr];
        end
      end
    end
  endtask

  // kind: 0=IRQ 1=BRK 2=NMI (the source expected to be taken).
  // brk is dropped after accept; irq/nmi are kept as levels when hold=1.
  task automatic run_seq(input string tag, input int kind, input logic [15:0] pc_i,
                         input logic [7:0] ps_i, input logic [7:0] sp_i,
                         input logic irq_i, input logic brk_i, input logic nmi_i,
                         input bit hold, input int waits, input int nmi_pulse_at);
    logic [15:0] vec;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic [7:0]  got_sp, got_ps;
    logic [15:0] got_pc;
    int busy_cnt, n_sp, n_ps, n_pc, n_done, overlap;
    bit fin;
    vec = (kind == 2) ? 16'hFFFA : 16'hFFFE;
    busy_cnt = 0; n_sp = 0; n_ps = 0; n_pc = 0; n_done = 0; overlap = 0; fin = 0;
    got_sp = 0; got_ps = 0; got_pc = 0;
    cur_waits = waits; req_cnt = 0; wlog.delete();
    pc = pc_i; ps = ps_i; sp = sp_i; irq = irq_i; brk_req = brk_i; nmi = nmi_i; can_take = 1'b1;
    @(negedge clk);
    chk({tag, "_accept"}, {31'd0, busy}, 32'd1);
    brk_req = 1'b0;
    if (!hold) begin
      irq = 1'b0; nmi = 1'b0;
      pc = 16'($urandom); sp = 8'($urandom); ps = 8'($urandom);
    end
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (cyc == nmi_pulse_at) nmi = 1'b1;
      else if (cyc == nmi_pulse_at + 1) nmi = 1'b0;
      if (busy) busy_cnt++;
      if (we_sp) begin n_sp++; got_sp = reg_data; end
      if (we_ps) begin n_ps++; got_ps = reg_data; if (we_sp) overlap++; end
      if (we_pc) begin n_pc++; got_pc = pc_out; end
      if (done) begin n_done++; fin = 1; end
      mem_step();
      @(negedge clk);
    end
    chk({tag, "_done"}, n_done, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, 7 + 5 * waits);
    chk({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    chk({tag, "_strobes"}, {n_sp[7:0], n_ps[7:0], n_pc[7:0]}, 24'h010101);
    chk({tag, "_sp_ps_overlap"}, overlap, 0);
    chk({tag, "_push_count"}, wlog.size(), 3);
    for (int k = 0; k < 3; k++) begin
      exp_addr = {8'h01, 8'(sp_i - 8'(k))};
      case (k)
        0:       exp_data = pc_i / 256;
        1:       exp_data = pc_i % 256;
        default: exp_data = (ps_i | 8'h20) & 8'hEF | ((kind == 1) ? 8'h10 : 8'h00);
      endcase
      if (k < wlog.size()) chk($sformatf("%s_push%0d", tag, k), wlog[k], {exp_addr, exp_data});
    end
    chk({tag, "_sp_write"}, got_sp, 8'(sp_i - 8'd3));
    chk({tag, "_ps_write"}, got_ps, ps_i | 8'h04);
    chk({tag, "_pc_write"}, got_pc, {mem[vec + 16'd1], mem[vec]});
  endtask

  task automatic idle_watch(input string tag, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || mem_req || we_sp || we_ps || we_pc || done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    reset = 1'b1; irq = 0; nmi = 0; brk_req = 0; can_take = 0;
    pc = 0; ps = 0; sp = 0; mem_rdata = 0; mem_ack = 0;
    cur_waits = 0; req_cnt = 0; req_snap = 0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {22'd0, busy, done, reg_data, we_sp, we_ps, we_pc, mem_req, mem_we}, 32'd0);
    chk("reset_data", {pc_out, mem_addr}, 32'd0);
    chk("reset_wdata", mem_wdata, 8'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reference IRQ example
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'h80;
    run_seq("irq", 0, 16'h1234, 8'h20, 8'hFD, 1, 0, 0, 0, 0, -10);

    // BRK with pushed B bit
    mem[16'hFFFE] = 8'h56; mem[16'hFFFF] = 8'hC3;
    run_seq("brk", 1, 16'h0302, 8'h00, 8'hFD, 0, 1, 0, 0, 0, -10);

    // Masked IRQ never accepted
    ps = 8'h24; irq = 1'b1; can_take = 1'b1;
    idle_watch("masked_irq", 20);
    irq = 1'b0;

    // can_take low blocks an unmasked IRQ
    ps = 8'h00; irq = 1'b1; can_take = 1'b0;
    idle_watch("no_can_take", 10);
    irq = 1'b0;
    @(negedge clk);

    // Stack pointer wrap 01 -> FE
    run_seq("wrap", 0, 16'hBEEF, 8'h81, 8'h01, 1, 0, 0, 0, 0, -10);

    // Wait states: ack in the third cycle of every access
    run_seq("wait", 1, 16'h4321, 8'hC3, 8'h40, 0, 1, 0, 0, 2, -10);

    // BRK and IRQ together: BRK first, IRQ (still held) right after
    mem[16'hFFFE] = 8'h10; mem[16'hFFFF] = 8'h20;
    run_seq("brk_over_irq", 1, 16'h7000, 8'h01, 8'hF0, 1, 1, 0, 1, 0, -10);
    run_seq("irq_after_brk", 0, 16'h7000, 8'h01, 8'hF0, 1, 0, 0, 0, 0, -10);

`ifdef CPU_NMI_EN
    mem[16'hFFFA] = 8'h11; mem[16'hFFFB] = 8'hC0;
    run_seq("nmi_over_irq", 2, 16'h2222, 8'h02, 8'hE0, 1, 0, 1, 1, 0, -10);
    run_seq("irq_after_nmi", 0, 16'h2222, 8'h02, 8'hE0, 1, 0, 1, 0, 0, -10);
    run_seq("irq_nmi_edge", 0, 16'h3333, 8'h00, 8'hD0, 1, 0, 0, 0, 1, 3);
    run_seq("nmi_pending", 2, 16'h4444, 8'h40, 8'hC0, 0, 0, 0, 0, 0, -10);
    idle_watch("nmi_consumed", 10);
`else
    nmi = 1'b1; can_take = 1'b1; ps = 8'h00;
    idle_watch("nmi_ignored", 20);
    nmi = 1'b0;
    @(negedge clk);
`endif

    // Reset in the middle of PUSH_PCL
    cur_waits = 0; req_cnt = 0; wlog.delete();
    pc = 16'hABCD; ps = 8'h00; sp = 8'h80; irq = 1'b1; can_take = 1'b1;
    @(negedge clk);
    chk("abort_accept", {31'd0, busy}, 32'd1);
    irq = 1'b0;
    mem_step();
    @(negedge clk);
    chk("abort_pcl_addr", mem_addr, 16'h017F);
    mem_ack = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("abort_ctrl", {22'd0, busy, done, reg_data, we_sp, we_ps, we_pc, mem_req, mem_we}, 32'd0);
    chk("abort_data", {pc_out, mem_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle_watch("abort_quiet", 15);

    // Randomized sequences against the reference model
    for (int it = 0; it < 20; it++) begin
      int kind;
      logic [7:0] ps_r;
      kind = $urandom_range(0, 1);
      ps_r = 8'($urandom);
      if (kind == 0) ps_r[2] = 1'b0;
      mem[16'hFFFE] = 8'($urandom); mem[16'hFFFF] = 8'($urandom);
      run_seq($sformatf("rand%0d", it), kind, 16'($urandom), ps_r, 8'($urandom),
              (kind == 0) ? 1'b1 : 1'($urandom), (kind == 1), 0, 0,
              $urandom_range(0, 3), -10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
